// File: rtl/reg_tap_line.sv
// reg_tap_line: DEPTH-tap sample delay line with parallel taps, registered tap read port and fill tracking.
module reg_tap_line #(
  parameter int N     = 23,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int SW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic [N-1:0]         din,
  input  logic [SW-1:0]        tap_sel,
  output logic [N*DEPTH-1:0]   taps,
  output logic [N-1:0]         tap_out,
  output logic                 out_valid,
  output logic [CW-1:0]        fill_cnt,
  output logic                 primed
);
  logic [N-1:0]  tap_q [DEPTH];
  logic [N-1:0]  tap_d [DEPTH];
  logic [N-1:0]  sel_tap;
  logic [N-1:0]  tap_out_q, tap_out_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          primed_q, primed_d;

  // selects past the last tap fall through to zero
  always_comb begin
    sel_tap = '0;
    for (int k = 0; k < DEPTH; k++) if (tap_sel == SW'(k)) sel_tap = tap_q[k];
    tap_d[0] = clr ? '0 : in_valid ? din : tap_q[0];
    for (int k = 1; k < DEPTH; k++) tap_d[k] = clr ? '0 : in_valid ? tap_q[k-1] : tap_q[k];
    tap_out_d   = clr ? '0 : sel_tap;
    out_valid_d = in_valid & ~clr;
    fill_d      = clr ? '0 : (in_valid && fill_q != CW'(DEPTH)) ? fill_q + CW'(1) : fill_q;
    primed_d    = fill_d == CW'(DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_q       <= '{default: '0};
      tap_out_q   <= '0;
      out_valid_q <= 1'b0;
      fill_q      <= '0;
      primed_q    <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      tap_out_q   <= tap_out_d;
      out_valid_q <= out_valid_d;
      fill_q      <= fill_d;
      primed_q    <= primed_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_taps
    assign taps[N*i +: N] = tap_q[i];
  end

  assign tap_out   = tap_out_q;
  assign out_valid = out_valid_q;
  assign fill_cnt  = fill_q;
  assign primed    = primed_q;
endmodule

// File: tb/tb_reg_tap_line.sv
// tb_reg_tap_line: checks DEPTH=8 and DEPTH=6 lines against a sample-history model plus literal expectations.
module tb_reg_tap_line;
  localparam int N = 23;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, in_valid = 1'b0;
  logic [N-1:0] din = '0;
  logic [2:0] tap_sel = '0;
  logic [N*8-1:0] taps8;
  logic [N*6-1:0] taps6;
  logic [N-1:0] to8, to6;
  logic ov8, ov6, pr8, pr6;
  logic [3:0] fc8;
  logic [2:0] fc6;
  int checks = 0, errors = 0;
  logic [N-1:0] q [$];
  logic [N-1:0] eto8 = '0, eto6 = '0;
  logic ov_m = 1'b0;
  int exp6 [8] = '{15, 14, 13, 12, 11, 10, 0, 0};

  reg_tap_line #(.N(N), .DEPTH(8)) dut8 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din(din),
    .tap_sel(tap_sel), .taps(taps8), .tap_out(to8), .out_valid(ov8), .fill_cnt(fc8), .primed(pr8));
  reg_tap_line #(.N(N), .DEPTH(6)) dut6 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din(din),
    .tap_sel(tap_sel), .taps(taps6), .tap_out(to6), .out_valid(ov6), .fill_cnt(fc6), .primed(pr6));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // q holds accepted samples newest-first, capped at the longest line
  function automatic logic [N-1:0] tap_m(input int d, input int k);
    return (k < d && k < q.size()) ? q[k] : '0;
  endfunction

  function automatic int fill_m(input int d);
    return q.size() < d ? q.size() : d;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      ov_m = 1'b0;
      eto8 = '0;
      eto6 = '0;
    end else begin
      eto8 = clr ? '0 : tap_m(8, int'(tap_sel));
      eto6 = clr ? '0 : tap_m(6, int'(tap_sel));
      ov_m = in_valid && !clr;
      if (clr) q.delete();
      else if (in_valid) begin
        q.push_front(din);
        if (q.size() > 8) void'(q.pop_back());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int k = 0; k < 8; k++) chk($sformatf("m_tap8[%0d]", k), 64'(taps8[k*N +: N]), 64'(tap_m(8, k)));
      for (int k = 0; k < 6; k++) chk($sformatf("m_tap6[%0d]", k), 64'(taps6[k*N +: N]), 64'(tap_m(6, k)));
      chk("m_tap_out8", 64'(to8), 64'(eto8));
      chk("m_tap_out6", 64'(to6), 64'(eto6));
      chk("m_ov8", 64'(ov8), 64'(ov_m));
      chk("m_ov6", 64'(ov6), 64'(ov_m));
      chk("m_fill8", 64'(fc8), 64'(fill_m(8)));
      chk("m_fill6", 64'(fc6), 64'(fill_m(6)));
      chk("m_primed8", 64'(pr8), 64'(fill_m(8) == 8));
      chk("m_primed6", 64'(pr6), 64'(fill_m(6) == 6));
    end
  end

  task automatic cyc(input logic v, input logic [N-1:0] d, input logic c);
    in_valid = v;
    din = d;
    clr = c;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_taps8"}, 64'(taps8 != '0), 64'd0);
    chk({nm, "_taps6"}, 64'(taps6 != '0), 64'd0);
    chk({nm, "_to"}, 64'({to8, to6}), 64'd0);
    chk({nm, "_ov"}, 64'({ov8, ov6}), 64'd0);
    chk({nm, "_fill"}, 64'({fc8, fc6}), 64'd0);
    chk({nm, "_primed"}, 64'({pr8, pr6}), 64'd0);
  endtask

  initial begin
    #1 chk_zero("rst_init");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tap_sel = 3'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), N'($urandom), 1'b0);
    end
    in_valid = 1'b1;
    din = N'($urandom);
    rst = 1'b1;
    #1 chk_zero("rst_mid");
    @(posedge clk);
    #2 rst = 1'b0;
    tap_sel = 3'd7;
    // fill and prime
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, N'(i), 1'b0);
      chk("fill_step", 64'(fc8), 64'(i));
      chk("fill_ov", 64'(ov8), 64'd1);
      chk("fill_primed", 64'(pr8), 64'(i == 8));
    end
    chk("prime_tap0", 64'(taps8[0 +: N]), 64'd8);
    chk("prime_tap7", 64'(taps8[7*N +: N]), 64'd1);
    chk("prime6_tap0", 64'(taps6[0 +: N]), 64'd8);
    chk("prime6_tap5", 64'(taps6[5*N +: N]), 64'd3);
    // overflow
    for (int i = 9; i <= 10; i++) begin
      cyc(1'b1, N'(i), 1'b0);
      chk("ovf_ov", 64'(ov8), 64'd1);
    end
    chk("ovf_tap0", 64'(taps8[0 +: N]), 64'd10);
    chk("ovf_tap7", 64'(taps8[7*N +: N]), 64'd3);
    chk("ovf_fill", 64'(fc8), 64'd8);
    chk("ovf_primed", 64'(pr8), 64'd1);
    chk("ovf_tap_out7", 64'(to8), 64'd2);
    // gapped strobes
    cyc(1'b1, 23'h7FFFFF, 1'b0);
    chk("gap_ov1", 64'(ov8), 64'd1);
    cyc(1'b0, 23'h000001, 1'b0);
    chk("gap_ov0a", 64'(ov8), 64'd0);
    chk("gap_hold", 64'(taps8[0 +: N]), 64'h7FFFFF);
    cyc(1'b0, 23'h000002, 1'b0);
    chk("gap_ov0b", 64'(ov8), 64'd0);
    chk("gap_hold_tap7", 64'(taps8[7*N +: N]), 64'd4);
    cyc(1'b1, 23'h400000, 1'b0);
    chk("gap_ov2", 64'(ov8), 64'd1);
    chk("gap_tap0", 64'(taps8[0 +: N]), 64'h400000);
    chk("gap_tap1", 64'(taps8[N +: N]), 64'h7FFFFF);
    // clear beats a simultaneous strobe
    cyc(1'b1, 23'h123456, 1'b1);
    chk_zero("clr");
    cyc(1'b0, '0, 1'b0);
    // tap read sweep
    for (int i = 0; i < 6; i++) cyc(1'b1, N'(10 + i), 1'b0);
    for (int s = 0; s < 8; s++) begin
      tap_sel = 3'(s);
      cyc(1'b0, '0, 1'b0);
      chk($sformatf("sweep6[%0d]", s), 64'(to6), 64'(exp6[s]));
      chk($sformatf("sweep8[%0d]", s), 64'(to8), 64'(exp6[s]));
    end
    chk("sweep_primed6", 64'(pr6), 64'd1);
    chk("sweep_primed8", 64'(pr8), 64'd0);
    chk("sweep_fill8", 64'(fc8), 64'd6);
    cyc(1'b0, '0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
